// File: rtl/gray_img_server.sv
// Image buffer between a pixel loader, an LBP engine and a result readback stream.
// Gray RAM is loaded in raster order, served to the engine, then LBP RAM is drained out.
module gray_img_server #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pix_in_valid,
   input  logic [DATA_W-1:0] pix_in_data,
   output logic              pix_in_ready,
   input  logic [ADDR_W-1:0] gray_addr,
   input  logic              gray_req,
   output logic              gray_ready,
   output logic [DATA_W-1:0] gray_data,
   input  logic [ADDR_W-1:0] lbp_addr,
   input  logic              lbp_valid,
   input  logic [DATA_W-1:0] lbp_data,
   input  logic              finish,
   output logic              res_valid,
   output logic [DATA_W-1:0] res_data,
   output logic              res_last,
   input  logic              res_ready,
   output logic [ADDR_W:0]   lbp_wr_cnt,
   output logic              done,
   input  logic              start
);

   localparam int unsigned     DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] FULL  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

   typedef enum logic [1:0] {S_LOAD, S_SERVE, S_DRAIN, S_DONE} state_t;

   state_t state, next_state;

   logic [ADDR_W:0]   ld_cnt;
   logic [ADDR_W:0]   rd_cnt;
   logic [DATA_W-1:0] gray_mem [DEPTH];
   logic [DATA_W-1:0] lbp_mem  [DEPTH];

   logic ld_hs, rd_hs, lbp_we, restart;

   assign ld_hs   = (state == S_LOAD) && pix_in_valid && pix_in_ready;
   assign lbp_we  = (state == S_SERVE) && lbp_valid;
   assign rd_hs   = res_valid && res_ready;
   assign restart = (state == S_DONE) && start;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         S_LOAD:  if (ld_hs && ld_cnt == LAST) next_state = S_SERVE;
         S_SERVE: if (finish) next_state = S_DRAIN;
         S_DRAIN: if (rd_hs && rd_cnt == LAST) next_state = S_DONE;
         S_DONE:  if (start) next_state = S_LOAD;
         default: next_state = S_LOAD;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_LOAD;
         ld_cnt       <= '0;
         rd_cnt       <= '0;
         lbp_wr_cnt   <= '0;
         pix_in_ready <= 1'b0;
         gray_ready   <= 1'b0;
      end else begin
         state        <= next_state;
         pix_in_ready <= (next_state == S_LOAD);
         gray_ready   <= (next_state == S_SERVE);
         if (restart) begin
            ld_cnt     <= '0;
            rd_cnt     <= '0;
            lbp_wr_cnt <= '0;
         end else begin
            if (ld_hs) ld_cnt <= (ld_cnt == LAST) ? '0 : ld_cnt + ONE;
            if (rd_hs) rd_cnt <= rd_cnt + ONE;
            if (lbp_we && lbp_wr_cnt != FULL) lbp_wr_cnt <= lbp_wr_cnt + ONE;
         end
      end
   end

   // NOTE: the image RAMs have no reset; contents survive both reset and restart.
   always_ff @(posedge clk) begin
      if (ld_hs)  gray_mem[ld_cnt[ADDR_W-1:0]] <= pix_in_data;
      if (lbp_we) lbp_mem[lbp_addr]            <= lbp_data;
   end

   // Zero-latency read: the engine samples gray_data on the edge after it moves gray_addr.
   assign gray_data = (gray_req && state == S_SERVE) ? gray_mem[gray_addr] : '0;

   assign res_valid = (state == S_DRAIN);
   assign res_data  = res_valid ? lbp_mem[rd_cnt[ADDR_W-1:0]] : '0;
   assign res_last  = res_valid && (rd_cnt == LAST);
   assign done      = (state == S_DONE);

endmodule

// File: tb/tb_gray_img_server.sv
// Directed bench for gray_img_server: load, serve, LBP write, drain, restart and mid-drain reset.
module tb_gray_img_server;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              pix_in_valid = 1'b0;
   logic [DATA_W-1:0] pix_in_data = '0;
   logic              pix_in_ready;
   logic [ADDR_W-1:0] gray_addr = '0;
   logic              gray_req = 1'b0;
   logic              gray_ready;
   logic [DATA_W-1:0] gray_data;
   logic [ADDR_W-1:0] lbp_addr = '0;
   logic              lbp_valid = 1'b0;
   logic [DATA_W-1:0] lbp_data = '0;
   logic              finish = 1'b0;
   logic              res_valid;
   logic [DATA_W-1:0] res_data;
   logic              res_last;
   logic              res_ready = 1'b0;
   logic [ADDR_W:0]   lbp_wr_cnt;
   logic              done;
   logic              start = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   gray_img_server #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset),
      .pix_in_valid(pix_in_valid), .pix_in_data(pix_in_data), .pix_in_ready(pix_in_ready),
      .gray_addr(gray_addr), .gray_req(gray_req), .gray_ready(gray_ready), .gray_data(gray_data),
      .lbp_addr(lbp_addr), .lbp_valid(lbp_valid), .lbp_data(lbp_data), .finish(finish),
      .res_valid(res_valid), .res_data(res_data), .res_last(res_last), .res_ready(res_ready),
      .lbp_wr_cnt(lbp_wr_cnt), .done(done), .start(start)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] pat1(input int a);
      return DATA_W'(a % 251);
   endfunction

   function automatic logic [DATA_W-1:0] pat2(input int a);
      return DATA_W'(255 - (a % 251));
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pix_rdy"},   32'(pix_in_ready), 32'd0);
      check({tag, "_gray_rdy"},  32'(gray_ready),   32'd0);
      check({tag, "_res_valid"}, 32'(res_valid),    32'd0);
      check({tag, "_res_last"},  32'(res_last),     32'd0);
      check({tag, "_done"},      32'(done),         32'd0);
      check({tag, "_wr_cnt"},    32'(lbp_wr_cnt),   32'd0);
   endtask

   initial begin
      int acc, cyc;
      logic tog, hs;

      // Reset held: outputs at reset values
      #1;
      check_reset_outputs("rst_hold");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1 check("pix_rdy_before_edge", 32'(pix_in_ready), 32'd0);
      @(negedge clk);
      check("pix_rdy_after_edge", 32'(pix_in_ready), 32'd1);

      // First load, no gaps; lbp_valid during LOAD must be ignored
      lbp_valid = 1'b1; lbp_addr = 14'd7; lbp_data = 8'hEE;
      for (int a = 0; a < DEPTH; a++) begin
         pix_in_valid = 1'b1;
         pix_in_data  = pat1(a);
         if (a == 3) lbp_valid = 1'b0;
         if (a == DEPTH - 1) begin
            check("load1_gray_rdy_before_last", 32'(gray_ready), 32'd0);
            check("load1_pix_rdy_before_last",  32'(pix_in_ready), 32'd1);
         end
         @(negedge clk);
      end
      check("load1_gray_rdy",  32'(gray_ready),   32'd1);
      check("load1_pix_rdy",   32'(pix_in_ready), 32'd0);
      check("load1_wr_cnt",    32'(lbp_wr_cnt),   32'd0);

      // Pixel offered in SERVE is ignored; start in SERVE is ignored
      pix_in_data = 8'hFF; start = 1'b1;
      @(negedge clk);
      pix_in_valid = 1'b0; start = 1'b0;
      check("serve_start_ignored", 32'(gray_ready), 32'd1);

      gray_req = 1'b1; gray_addr = 14'd300;
      #1 check("rd_300", 32'(gray_data), 32'd49);
      gray_addr = 14'd16383;
      #1 check("rd_16383", 32'(gray_data), 32'd68);
      gray_addr = 14'd0;
      #1 check("rd_0_not_overwritten", 32'(gray_data), 32'd0);
      gray_req = 1'b0; gray_addr = 14'd300;
      #1 check("rd_no_req", 32'(gray_data), 32'd0);

      // LBP writes, same address twice
      @(negedge clk);
      lbp_valid = 1'b1; lbp_addr = 14'd5; lbp_data = 8'hA5;
      @(negedge clk);
      lbp_data = 8'h3C;
      @(negedge clk);
      check("wr_cnt_two", 32'(lbp_wr_cnt), 32'd2);
      lbp_addr = 14'd10; lbp_data = 8'h77;
      @(negedge clk);
      // Write and finish together on the last address
      lbp_addr = 14'd16383; lbp_data = 8'h81; finish = 1'b1; res_ready = 1'b1;
      @(negedge clk);
      lbp_valid = 1'b0;
      check("wr_cnt_four",   32'(lbp_wr_cnt), 32'd4);
      check("drain_entered", 32'(res_valid),  32'd1);
      check("drain_gray_rdy", 32'(gray_ready), 32'd0);

      // Drain all beats with a 3-cycle stall at beat 10
      for (int i = 0; i < DEPTH; i++) begin
         if (i == 0)  check("beat0_last", 32'(res_last), 32'd0);
         if (i == 5)  check("beat5_data", 32'(res_data), 32'h3C);
         if (i == 10) begin
            res_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               check("stall_data",  32'(res_data),  32'h77);
               check("stall_valid", 32'(res_valid), 32'd1);
            end
            res_ready = 1'b1;
         end
         if (i == DEPTH - 2) check("beat_prev_last", 32'(res_last), 32'd0);
         if (i == DEPTH - 1) begin
            check("last_data",  32'(res_data),  32'h81);
            check("last_flag",  32'(res_last),  32'd1);
            check("last_valid", 32'(res_valid), 32'd1);
         end
         @(negedge clk);
      end
      check("done_set",      32'(done),      32'd1);
      check("done_no_valid", 32'(res_valid), 32'd0);
      check("done_no_last",  32'(res_last),  32'd0);

      // Restart
      finish = 1'b0; res_ready = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("restart_pix_rdy", 32'(pix_in_ready), 32'd1);
      check("restart_done",    32'(done),         32'd0);
      check("restart_wr_cnt",  32'(lbp_wr_cnt),   32'd0);

      // Second load with valid toggling every other cycle
      acc = 0; cyc = 0; tog = 1'b1;
      while (acc < DEPTH && cyc < 4 * DEPTH) begin
         pix_in_valid = tog;
         pix_in_data  = pat2(acc);
         hs = tog && pix_in_ready;
         @(negedge clk);
         if (hs) begin
            acc++;
            if (acc == DEPTH - 1 || acc == DEPTH)
               check("load2_gray_rdy", 32'(gray_ready), 32'(acc == DEPTH));
            else if (acc % 4096 == 0)
               check("load2_pix_rdy", 32'(pix_in_ready), 32'd1);
         end
         tog = ~tog;
         cyc++;
      end
      pix_in_valid = 1'b0;
      check("load2_budget", 32'(acc), 32'(DEPTH));
      check("load2_pix_rdy_off", 32'(pix_in_ready), 32'd0);

      gray_req = 1'b1; gray_addr = 14'd300;
      #1 check("rd2_300", 32'(gray_data), 32'd206);
      gray_addr = 14'd5;
      #1 check("rd2_5", 32'(gray_data), 32'd250);
      gray_req = 1'b0;

      // Drain partially, then reset mid-DRAIN
      @(negedge clk);
      finish = 1'b1; res_ready = 1'b1;
      @(negedge clk);
      check("run2_wr_cnt", 32'(lbp_wr_cnt), 32'd0);
      check("run2_drain",  32'(res_valid),  32'd1);
      for (int i = 0; i < 8000; i++) begin
         if (i == 5) check("run2_beat5_kept", 32'(res_data), 32'h3C);
         @(negedge clk);
      end
      check("pre_reset_valid", 32'(res_valid), 32'd1);
      reset = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      finish = 1'b0; res_ready = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_pix_rdy",  32'(pix_in_ready), 32'd1);
      check("post_rst_gray_rdy", 32'(gray_ready),   32'd0);
      check("post_rst_valid",    32'(res_valid),    32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
